snitch_icache_perf_unit: RTL

Event-counting stage directly downstream of the instruction cache's event outputs. It consumes the per-fetch-port L0 event vectors and the shared L1 event vector, registers them, and accumulates them in saturating counters. Software or a debug agent reads the counters through a single-outstanding valid/ready read port. A read can optionally clear the counter it reads. The block sits beside the cluster icache and is observed through the cluster peripheral register file.

---
 rtl/snitch_icache_pkg.sv | 67 ++++++
 rtl/snitch_icache_perf_ctr.sv | 53 +++++
 rtl/snitch_icache_perf_unit.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/snitch_icache_pkg.sv
// Shared instruction-cache definitions used by the performance counter unit.
//
// Contents:
//   L0_EVT_COUNT / L1_EVT_COUNT  number of event fields per L0 port / in L1
//   icache_l0_events_t           per-fetch-port L0 event bits
//   icache_l1_events_t           shared L1 event bits
//   l0_evt_e / l1_evt_e          field offsets that define the counter index map
//   l0_evt_vec / l1_evt_vec      pack an event struct into an offset-indexed vector
package snitch_icache_pkg;

    localparam int unsigned L0_EVT_COUNT = 5;
    localparam int unsigned L1_EVT_COUNT = 4;

    typedef struct packed {
        logic miss;
        logic hit;
        logic prefetch;
        logic double_hit;
        logic stall;
    } icache_l0_events_t;

    typedef struct packed {
        logic miss;
        logic hit;
        logic stall;
        logic handler_stall;
    } icache_l1_events_t;

    // Offset of each field inside its group of counters.
    typedef enum logic [2:0] {
        L0_MISS       = 3'd0,
        L0_HIT        = 3'd1,
        L0_PREFETCH   = 3'd2,
        L0_DOUBLE_HIT = 3'd3,
        L0_STALL      = 3'd4
    } l0_evt_e;

    typedef enum logic [1:0] {
        L1_MISS          = 2'd0,
        L1_HIT           = 2'd1,
        L1_STALL         = 2'd2,
        L1_HANDLER_STALL = 2'd3
    } l1_evt_e;

    // Bit k of the result is the event counted by group counter k.
    function automatic logic [L0_EVT_COUNT-1:0] l0_evt_vec(input icache_l0_events_t e);
        logic [L0_EVT_COUNT-1:0] v;
        v                = '0;
        v[L0_MISS]       = e.miss;
        v[L0_HIT]        = e.hit;
        v[L0_PREFETCH]   = e.prefetch;
        v[L0_DOUBLE_HIT] = e.double_hit;
        v[L0_STALL]      = e.stall;
        return v;
    endfunction

    function automatic logic [L1_EVT_COUNT-1:0] l1_evt_vec(input icache_l1_events_t e);
        logic [L1_EVT_COUNT-1:0] v;
        v                   = '0;
        v[L1_MISS]          = e.miss;
        v[L1_HIT]           = e.hit;
        v[L1_STALL]         = e.stall;
        v[L1_HANDLER_STALL] = e.handler_stall;
        return v;
    endfunction

endpackage

// File: rtl/snitch_icache_perf_ctr.sv
// One saturating event counter.
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   clear_i         force the counter to zero (highest priority)
//   load_evt_i      read-and-clear: load the current event bit instead of counting
//   evt_i           event bit used by load_evt_i
//   inc_i           count one event (ignored once the counter is all-ones)
//   value_o         current counter value
//   at_max_o        the value being written this cycle is all-ones
module snitch_icache_perf_ctr #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 load_evt_i,
    input  logic                 evt_i,
    input  logic                 inc_i,
    output logic [CNT_WIDTH-1:0] value_o,
    output logic                 at_max_o
);

    logic [CNT_WIDTH-1:0] value_d, value_q;
    logic                 sat;

    assign sat = &value_q;

    always_comb begin
        value_d = value_q;
        if (clear_i) begin
            value_d = '0;
        end else if (load_evt_i) begin
            value_d = {{(CNT_WIDTH-1){1'b0}}, evt_i};
        end else if (inc_i && !sat) begin
            value_d = value_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    // Looks at the next value so the sticky overflow flag rises together
    // with the counter reaching all-ones.
    assign at_max_o = &value_d;

endmodule

// File: rtl/snitch_icache_perf_unit.sv
// Instruction-cache performance counter unit.
//
// Registers the L0/L1 event vectors, accumulates every event bit in its own
// saturating counter and serves single-outstanding counter reads.
//
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   enable_i        counting enable (applies to the registered events)
//   clear_all_i     zero all counters and the overflow flag
//   l0_events_i     per-fetch-port L0 events
//   l1_events_i     shared L1 events
//   req_*           read request (index, read-and-clear)
//   rsp_*           read response (snapshot, index error)
//   overflow_o      sticky: some counter reached all-ones
//
// Handshake: a transfer happens on a channel in every cycle where its valid
// and ready are both high. valid must not depend on ready; once rsp_valid_o
// is raised, rsp_data_o/rsp_err_o stay stable until rsp_ready_i accepts them.
// req_ready_o is high whenever the response register is empty or being
// drained, so back-to-back reads proceed without bubbles.
//
// Counter map: 5*p+k = port p L0 field k; 5*NR_FETCH_PORTS+k = L1 field k.
module snitch_icache_perf_unit
    import snitch_icache_pkg::*;
#(
    parameter int unsigned NR_FETCH_PORTS = 2,
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned NR_CNT         = L0_EVT_COUNT * NR_FETCH_PORTS + L1_EVT_COUNT,
    parameter int unsigned IDX_W          = $clog2(NR_CNT)
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic                                   enable_i,
    input  logic                                   clear_all_i,
    input  icache_l0_events_t [NR_FETCH_PORTS-1:0] l0_events_i,
    input  icache_l1_events_t                      l1_events_i,
    input  logic                                   req_valid_i,
    output logic                                   req_ready_o,
    input  logic [IDX_W-1:0]                       req_idx_i,
    input  logic                                   req_clear_i,
    output logic                                   rsp_valid_o,
    input  logic                                   rsp_ready_i,
    output logic [CNT_WIDTH-1:0]                   rsp_data_o,
    output logic                                   rsp_err_o,
    output logic                                   overflow_o
);

    localparam int unsigned L1_BASE = L0_EVT_COUNT * NR_FETCH_PORTS;

    logic [NR_CNT-1:0]    evt_d, evt_q;
    logic [CNT_WIDTH-1:0] cnt_val [NR_CNT];
    logic [NR_CNT-1:0]    cnt_at_max;

    logic                 req_fire;
    logic                 idx_ok;
    logic [CNT_WIDTH-1:0] rd_data;

    logic                 rsp_valid_d, rsp_valid_q;
    logic [CNT_WIDTH-1:0] rsp_data_d, rsp_data_q;
    logic                 rsp_err_d, rsp_err_q;
    logic                 overflow_d, overflow_q;

    // Flatten the event structs into counter-index order.
    always_comb begin
        evt_d = '0;
        for (int p = 0; p < NR_FETCH_PORTS; p++) begin
            evt_d[p*L0_EVT_COUNT +: L0_EVT_COUNT] = l0_evt_vec(l0_events_i[p]);
        end
        evt_d[L1_BASE +: L1_EVT_COUNT] = l1_evt_vec(l1_events_i);
    end

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign idx_ok      = {1'b0, req_idx_i} < (IDX_W+1)'(NR_CNT);

    for (genvar i = 0; i < NR_CNT; i++) begin : g_ctr
        logic load;
        // Out-of-range indices never match, so req_clear_i has no effect for them.
        assign load = req_fire && req_clear_i && (req_idx_i == IDX_W'(i));

        snitch_icache_perf_ctr #(
            .CNT_WIDTH (CNT_WIDTH)
        ) i_ctr (
            .clk_i      (clk_i),
            .rst_ni     (rst_ni),
            .clear_i    (clear_all_i),
            .load_evt_i (load),
            .evt_i      (evt_q[i]),
            .inc_i      (enable_i && evt_q[i]),
            .value_o    (cnt_val[i]),
            .at_max_o   (cnt_at_max[i])
        );
    end

    // Snapshot is taken from the registered counter, i.e. before this
    // cycle's update or clear; unmatched indices read as zero.
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NR_CNT; i++) begin
            if (req_idx_i == IDX_W'(i)) begin
                rd_data = cnt_val[i];
            end
        end
    end

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        if (req_fire) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = rd_data;
            rsp_err_d   = !idx_ok;
        end else if (rsp_ready_i) begin
            rsp_valid_d = 1'b0;
        end
    end

    assign overflow_d = clear_all_i ? 1'b0 : (overflow_q || (|cnt_at_max));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            evt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            evt_q       <= evt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            overflow_q  <= overflow_d;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_err_o   = rsp_err_q;
    assign overflow_o  = overflow_q;

endmodule
